// File: rtl/sram_1p_arbiter.sv
// Read/write arbiter and controller for one single-port synchronous SRAM macro.
// Optional post-reset array clear is enabled by defining SRAM_ARB_INIT_EN.
module sram_1p_arbiter #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 20
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rd_valid,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ready,
  output logic          rd_resp_valid,
  output logic [DW-1:0] rd_data,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          init_done,
  output logic          sram_ceb,
  output logic          sram_web,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q
);

  logic          run;
  logic          init_wr;
  logic [AW-1:0] init_addr;
  logic          rd_grant;
  logic          wr_grant;
  logic          last_wr_reg;
  logic          resp_reg;
  logic [DW-1:0] hold_reg;

`ifdef SRAM_ARB_INIT_EN
  typedef enum logic {INIT, RUN} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Outputs are held at their reset values while reset is asserted.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    init_wr    = 1'b0;
    run        = 1'b0;
    if (!reset) begin
      case (state_reg)
        INIT: begin
          init_wr  = 1'b1;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == AW'(DEPTH - 1))
            state_next = RUN;
        end
        RUN:     run = 1'b1;
        default: state_next = INIT;
      endcase
    end
  end

  assign init_addr = cnt_reg;
`else
  assign run       = ~reset;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  // Round-robin only matters under contention: last_wr=1 lets the read win.
  assign rd_grant  = run & rd_valid & (~wr_valid | last_wr_reg);
  assign wr_grant  = run & wr_valid & (~rd_valid | ~last_wr_reg);
  assign rd_ready  = rd_grant;
  assign wr_ready  = wr_grant;
  assign init_done = run;

  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (init_wr) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = init_addr;
    end else if (wr_grant) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = wr_addr;
      sram_d   = wr_data;
    end else if (rd_grant) begin
      sram_ceb = 1'b0;
      sram_a   = rd_addr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_wr_reg <= 1'b1;
      resp_reg    <= 1'b0;
      hold_reg    <= '0;
    end else begin
      if (wr_grant)
        last_wr_reg <= 1'b1;
      else if (rd_grant)
        last_wr_reg <= 1'b0;
      resp_reg <= rd_grant;
      if (resp_reg)
        hold_reg <= sram_q;
    end
  end

  // Macro Q is only meaningful in the response cycle; otherwise replay the held word.
  assign rd_resp_valid = resp_reg;
  assign rd_data       = resp_reg ? sram_q : hold_reg;

endmodule

// File: tb/tb_sram_1p_arbiter.sv
// Directed bench for sram_1p_arbiter with a behavioural single-port SRAM model.
// Covers both builds: with and without SRAM_ARB_INIT_EN.
module tb_sram_1p_arbiter;

  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int DW    = 20;
  localparam logic [DW-1:0] POISON = 20'h5A5A5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rd_valid = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ready;
  logic          rd_resp_valid;
  logic [DW-1:0] rd_data;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          init_done;
  logic          sram_ceb;
  logic          sram_web;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  sram_1p_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_resp_valid(rd_resp_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .init_done(init_done),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q)
  );

  // SRAM macro model: one-cycle read latency, Q is garbage when not reading.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q_reg = '0;
  logic          q_live = 1'b0;

  always @(posedge clock) begin
    q_live <= 1'b0;
    if (!sram_ceb) begin
      if (!sram_web) mem[sram_a] <= sram_d;
      else begin
        q_reg  <= mem[sram_a];
        q_live <= 1'b1;
      end
    end
  end
  assign sram_q = q_live ? q_reg : POISON;

  typedef struct {
    logic          rv;
    logic [AW-1:0] ra;
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          e_rr, e_wr, e_resp;
    logic [DW-1:0] e_data;
    logic          e_ceb, e_web;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mkv(input logic rv, input logic [AW-1:0] ra,
                               input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic rr, input logic wr, input logic resp,
                               input logic [DW-1:0] data, input logic ceb, input logic web,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    vec_t v;
    v.rv = rv; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd;
    v.e_rr = rr; v.e_wr = wr; v.e_resp = resp; v.e_data = data;
    v.e_ceb = ceb; v.e_web = web; v.e_a = a; v.e_d = d;
    return v;
  endfunction

  // {rd_ready, wr_ready, rd_resp_valid, rd_data, init_done, ceb, web, a, d}
  function automatic logic [52:0] outs();
    return {rd_ready, wr_ready, rd_resp_valid, rd_data, init_done,
            sram_ceb, sram_web, sram_a, sram_d};
  endfunction

  function automatic logic [52:0] pack(input logic rr, input logic wr, input logic resp,
                                       input logic [DW-1:0] data, input logic idone,
                                       input logic ceb, input logic web,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {rr, wr, resp, data, idone, ceb, web, a, d};
  endfunction

  task automatic check(input string name, input logic [52:0] got, input logic [52:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got rr/wr/resp/data/idone/ceb/web/a/d=%0b/%0b/%0b/%h/%0b/%0b/%0b/%h/%h want %0b/%0b/%0b/%h/%0b/%0b/%0b/%h/%h",
               name, got[52], got[51], got[50], got[49:30], got[29], got[28], got[27], got[26:20], got[19:0],
               exp[52], exp[51], exp[50], exp[49:30], exp[29], exp[28], exp[27], exp[26:20], exp[19:0]);
    end else
      $display("ok   %s", name);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b want %0b", name, got, exp);
    end else
      $display("ok   %s", name);
  endtask

  task automatic check_reset_vals(input string name);
    check(name, outs(), pack(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, '0, '0));
  endtask

  // Called at a negedge in RUN: read handshake, then reset during its response cycle.
  task automatic mid_read_reset(input logic [AW-1:0] a);
    rd_valid = 1'b1; rd_addr = a; wr_valid = 1'b0;
    #1 check_bit("mrr_ready", rd_ready & init_done, 1'b1);
    @(negedge clock);
    rd_valid = 1'b0;
    #1 check_bit("mrr_resp_before_reset", rd_resp_valid, 1'b1);
    reset = 1'b1;
    #1 check_reset_vals("mrr_reset_vals");
    @(negedge clock);
    reset = 1'b0;
    #1 check_bit("mrr_no_resp_after_release", rd_resp_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mkv(0,   0, 0,   0, 20'h00000, 0,0,0,20'h00000, 1,1,  0,20'h00000);
    tbl[1]  = mkv(0,   0, 1,   3, 20'hABCDE, 0,1,0,20'h00000, 0,0,  3,20'hABCDE);
    tbl[2]  = mkv(1,   3, 0,   0, 20'h00000, 1,0,0,20'h00000, 0,1,  3,20'h00000);
    tbl[3]  = mkv(0,   0, 0,   0, 20'h00000, 0,0,1,20'hABCDE, 1,1,  0,20'h00000);
    tbl[4]  = mkv(0,   0, 0,   0, 20'h00000, 0,0,0,20'hABCDE, 1,1,  0,20'h00000);
    tbl[5]  = mkv(0,   0, 1,   1, 20'h00011, 0,1,0,20'hABCDE, 0,0,  1,20'h00011);
    tbl[6]  = mkv(0,   0, 1,   2, 20'h00022, 0,1,0,20'hABCDE, 0,0,  2,20'h00022);
    tbl[7]  = mkv(0,   0, 1,   3, 20'h00033, 0,1,0,20'hABCDE, 0,0,  3,20'h00033);
    tbl[8]  = mkv(1,   1, 0,   0, 20'h00000, 1,0,0,20'hABCDE, 0,1,  1,20'h00000);
    tbl[9]  = mkv(1,   2, 0,   0, 20'h00000, 1,0,1,20'h00011, 0,1,  2,20'h00000);
    tbl[10] = mkv(1,   3, 0,   0, 20'h00000, 1,0,1,20'h00022, 0,1,  3,20'h00000);
    tbl[11] = mkv(0,   0, 0,   0, 20'h00000, 0,0,1,20'h00033, 1,1,  0,20'h00000);
    tbl[12] = mkv(0,   0, 0,   0, 20'h00000, 0,0,0,20'h00033, 1,1,  0,20'h00000);
    tbl[13] = mkv(0,   0, 1,  10, 20'h0F00F, 0,1,0,20'h00033, 0,0, 10,20'h0F00F);
    tbl[14] = mkv(1,  10, 1,  20, 20'h12345, 1,0,0,20'h00033, 0,1, 10,20'h00000);
    tbl[15] = mkv(1,  10, 1,  20, 20'h12345, 0,1,1,20'h0F00F, 0,0, 20,20'h12345);
    tbl[16] = mkv(1,  10, 1,  20, 20'h12345, 1,0,0,20'h0F00F, 0,1, 10,20'h00000);
    tbl[17] = mkv(1,  10, 1,  20, 20'h12345, 0,1,1,20'h0F00F, 0,0, 20,20'h12345);
    tbl[18] = mkv(0,   0, 0,   0, 20'h00000, 0,0,0,20'h0F00F, 1,1,  0,20'h00000);
    tbl[19] = mkv(1,  20, 0,   0, 20'h00000, 1,0,0,20'h0F00F, 0,1, 20,20'h00000);
    tbl[20] = mkv(0,   0, 0,   0, 20'h00000, 0,0,1,20'h12345, 1,1,  0,20'h00000);
    tbl[21] = mkv(0,   0, 1, 127, 20'hFFFFF, 0,1,0,20'h12345, 0,0,127,20'hFFFFF);
    tbl[22] = mkv(1, 127, 0,   0, 20'h00000, 1,0,0,20'h12345, 0,1,127,20'h00000);
    tbl[23] = mkv(0,   0, 0,   0, 20'h00000, 0,0,1,20'hFFFFF, 1,1,  0,20'h00000);
    tbl[24] = mkv(0,   0, 1,   0, 20'h00001, 0,1,0,20'hFFFFF, 0,0,  0,20'h00001);

    // Requests present during reset must not be granted.
    rd_valid = 1'b1; wr_valid = 1'b1; wr_data = 20'h77777;
    @(negedge clock);
    @(negedge clock);
    #1 check_reset_vals("reset_vals");
    @(negedge clock);
    reset = 1'b0;

`ifdef SRAM_ARB_INIT_EN
    for (int c = 0; c < 60; c++) begin
      #1 check($sformatf("init_pre_c%0d", c), outs(),
               pack(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, AW'(c), '0));
      @(negedge clock);
    end
    #1 reset = 1'b1;
    #1 check_reset_vals("reset_mid_init");
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < DEPTH; c++) begin
      #1 check($sformatf("init_c%0d", c), outs(),
               pack(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, AW'(c), '0));
      @(negedge clock);
    end
    wr_valid = 1'b0; wr_data = '0; rd_addr = 7'd5;
    #1 check("init_done_read5", outs(),
             pack(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 7'd5, '0));
    @(negedge clock);
    rd_valid = 1'b0;
    #1 check("read5_resp_zero", outs(),
             pack(1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b1, 1'b1, '0, '0));
    @(negedge clock);
    mid_read_reset(7'd5);
`else
    wr_valid = 1'b0; wr_data = '0;
    mid_read_reset(7'd0);
`endif

    begin : wait_init
      bit seen = 1'b0;
      for (int c = 0; c < 4 * DEPTH; c++) begin
        #1;
        if (init_done) begin
          seen = 1'b1;
          break;
        end
        @(negedge clock);
      end
      check_bit("init_done_within_budget", seen, 1'b1);
      @(negedge clock);
    end

    for (int i = 0; i < 25; i++) begin
      rd_valid = tbl[i].rv; rd_addr = tbl[i].ra;
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      #1 check($sformatf("vec%0d", i), outs(),
               pack(tbl[i].e_rr, tbl[i].e_wr, tbl[i].e_resp, tbl[i].e_data, 1'b1,
                    tbl[i].e_ceb, tbl[i].e_web, tbl[i].e_a, tbl[i].e_d));
      @(negedge clock);
    end

    // Held read data must survive idle cycles while the macro Q is garbage.
    rd_valid = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1 check($sformatf("hold_idle%0d", i), outs(),
               pack(1'b0, 1'b0, 1'b0, 20'hFFFFF, 1'b1, 1'b1, 1'b1, '0, '0));
      @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
